nco_angle_sequencer: RTL and testbench

- Upstream stage of the pipelined 16-bit CORDIC rotator.
- Generates the per-sample rotation angle (phase accumulator with optional linear chirp) plus gain-precompensated x_start/y_start.
- Runs one programmed burst of N samples per configuration handshake.
- Carries a valid/last pipeline matched to the rotator latency, so downstream logic knows exactly when SINout/COSout are meaningful.

---
 rtl/nco_angle_sequencer_if.sv | 22 ++
 rtl/nco_angle_sequencer.sv | 142 ++++++++++++++
 tb/tb_nco_angle_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_angle_sequencer_if.sv
// Configuration handshake bundle for the NCO angle sequencer.
// The sequencer is the slave; the burst controller drives it as master.
interface nco_angle_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_phase0;
    logic [WIDTH-1:0] cfg_fstart;
    logic [WIDTH-1:0] cfg_fstep;
    logic [15:0]      cfg_count;

    modport master (
        output cfg_valid, cfg_phase0, cfg_fstart, cfg_fstep, cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_phase0, cfg_fstart, cfg_fstep, cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/nco_angle_sequencer.sv
// Burst angle generator feeding the pipelined CORDIC rotator.
// Phase accumulator with linear chirp and a valid/last delay line.
module nco_angle_sequencer #(
    parameter int WIDTH      = 16,
    parameter int CORDIC_LAT = 17,
    parameter int X_INIT     = 19898
) (
    input  logic                     clk,
    input  logic                     reset,
    nco_angle_sequencer_if.slave     cfg,
    input  logic                     sample_en,
    input  logic                     abort,
    output logic [WIDTH-1:0]         angle,
    output logic [WIDTH-1:0]         x_start,
    output logic [WIDTH-1:0]         y_start,
    output logic                     angle_valid,
    output logic                     out_valid,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      phase_q, phase_d;
    logic [WIDTH-1:0]      freq_q, freq_d;
    logic [WIDTH-1:0]      step_q, step_d;
    logic [15:0]           rem_q, rem_d;
    logic                  zero_q, zero_d;
    logic [WIDTH-1:0]      angle_q, angle_d;
    logic [WIDTH-1:0]      xs_q, xs_d;
    logic                  av_q, av_d;
    logic                  al_q, al_d;
    logic [CORDIC_LAT-1:0] vp_q, vp_d;
    logic [CORDIC_LAT-1:0] lp_q, lp_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    // Next-state: abort beats everything; a zero-count burst drains at once.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        freq_d  = freq_q;
        step_d  = step_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        xs_d    = xs_q;
        av_d    = 1'b0;
        al_d    = 1'b0;
        done_d  = 1'b0;
        vp_d    = {vp_q[CORDIC_LAT-2:0], av_q};
        lp_d    = {lp_q[CORDIC_LAT-2:0], al_q};
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            vp_d    = '0;
            lp_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cfg.cfg_valid && ready_q) begin
                        phase_d = cfg.cfg_phase0;
                        freq_d  = cfg.cfg_fstart;
                        step_d  = cfg.cfg_fstep;
                        rem_d   = cfg.cfg_count;
                        zero_d  = (cfg.cfg_count == 16'd0);
                        state_d = zero_d ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (sample_en) begin
                        angle_d = phase_q;
                        xs_d    = WIDTH'(X_INIT);
                        av_d    = 1'b1;
                        phase_d = phase_q + freq_q;
                        freq_d  = freq_q + step_q;
                        rem_d   = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            al_d    = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (zero_q || (vp_q[CORDIC_LAT-1] && lp_q[CORDIC_LAT-1])) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            freq_q  <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            xs_q    <= '0;
            av_q    <= 1'b0;
            al_q    <= 1'b0;
            vp_q    <= '0;
            lp_q    <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            freq_q  <= freq_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            xs_q    <= xs_d;
            av_q    <= av_d;
            al_q    <= al_d;
            vp_q    <= vp_d;
            lp_q    <= lp_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign angle         = angle_q;
    assign x_start       = xs_q;
    assign y_start       = '0;
    assign angle_valid   = av_q;
    assign out_valid     = vp_q[CORDIC_LAT-1];
    assign out_last      = lp_q[CORDIC_LAT-1];
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
endmodule

// File: tb/tb_nco_angle_sequencer.sv
// Bench for nco_angle_sequencer: closed-form angle model with a
// time-stamped output schedule, plus hand-computed burst checks.
module tb_nco_angle_sequencer;
    localparam int LAT = 17;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_en = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] angle, x_start, y_start;
    logic        angle_valid, out_valid, out_last, busy, done;

    nco_angle_sequencer_if #(.WIDTH(16)) cfg_if ();

    nco_angle_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_if),
        .sample_en   (sample_en),
        .abort       (abort),
        .angle       (angle),
        .x_start     (x_start),
        .y_start     (y_start),
        .angle_valid (angle_valid),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_ZERO} mode_t;
    typedef struct {
        int t;
        bit last;
    } ev_t;

    mode_t       mode = M_IDLE;
    ev_t         sched[$];
    int          cyc = 0;
    bit          model_ok = 0;
    logic [15:0] m_p0, m_fs, m_st;
    int          m_cnt, m_k;
    logic [15:0] e_angle = '0, e_xs = '0;
    bit          e_av = 0, e_ov = 0, e_ol = 0, e_done = 0, e_ready = 0;

    // Angle of sample k: p0 + k*f0 + step*k*(k-1)/2, modulo 2^16.
    function automatic logic [15:0] ang(input int k);
        longint kk, a;
        kk = k;
        a = longint'(m_p0) + kk * longint'(m_fs)
            + longint'($signed(m_st)) * (kk * (kk - 1) / 2);
        return a[15:0];
    endfunction

    always @(posedge clk) begin
        bit pov, pol;
        ev_t ev;
        cyc++;
        pov = e_ov;
        pol = e_ol;
        e_av = 0;
        e_done = 0;
        e_ov = 0;
        e_ol = 0;
        if (reset) begin
            mode = M_IDLE;
            e_ready = 0;
            e_angle = '0;
            e_xs = '0;
            sched.delete();
            model_ok = 1;
        end else begin
            if (mode != M_IDLE && abort) begin
                mode = M_IDLE;
                sched.delete();
            end else begin
                case (mode)
                    M_IDLE: if (cfg_if.cfg_valid && e_ready) begin
                        m_p0 = cfg_if.cfg_phase0;
                        m_fs = cfg_if.cfg_fstart;
                        m_st = cfg_if.cfg_fstep;
                        m_cnt = int'(cfg_if.cfg_count);
                        m_k = 0;
                        mode = (m_cnt == 0) ? M_ZERO : M_RUN;
                    end
                    M_RUN: if (sample_en) begin
                        e_angle = ang(m_k);
                        e_xs = 16'd19898;
                        e_av = 1;
                        ev.t = cyc + LAT;
                        ev.last = (m_k == m_cnt - 1);
                        sched.push_back(ev);
                        m_k++;
                        if (ev.last) mode = M_DRAIN;
                    end
                    M_DRAIN: if (pov && pol) begin
                        e_done = 1;
                        mode = M_IDLE;
                    end
                    M_ZERO: begin
                        e_done = 1;
                        mode = M_IDLE;
                    end
                endcase
            end
            e_ready = (mode == M_IDLE);
        end
        if (sched.size() > 0 && sched[0].t == cyc) begin
            e_ov = 1;
            e_ol = sched[0].last;
            void'(sched.pop_front());
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    logic [15:0] seen[$];
    int          av_cyc[$];
    int          ov_cyc[$];
    int          last_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("angle", angle, e_angle);
            chk("x_start", x_start, e_xs);
            chk("y_start", y_start, 0);
            chk("angle_valid", angle_valid, e_av);
            chk("out_valid", out_valid, e_ov);
            chk("out_last", out_last, e_ol);
            chk("done", done, e_done);
            chk("cfg_ready", cfg_if.cfg_ready, e_ready);
            chk("busy", busy, mode != M_IDLE);
            if (angle_valid) begin
                seen.push_back(angle);
                av_cyc.push_back(cyc);
            end
            if (out_valid) ov_cyc.push_back(cyc);
            if (out_valid && out_last) last_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [15:0] p0, input logic [15:0] fs,
                             input logic [15:0] st, input int cnt,
                             input int md, input int ab_at,
                             input int rs_at, input bit glitch);
        int i;
        bit fired;
        logic [4:0] pat;
        pat = 5'b11001;
        seen.delete();
        av_cyc.delete();
        ov_cyc.delete();
        done_cnt = 0;
        last_cyc = -1;
        done_cyc = -1;
        cfg_if.cfg_phase0 = p0;
        cfg_if.cfg_fstart = fs;
        cfg_if.cfg_fstep = st;
        cfg_if.cfg_count = cnt[15:0];
        cfg_if.cfg_valid = 1'b1;
        for (int w = 0; w < 50 && !cfg_if.cfg_ready; w++) tick();
        chk("cfg_accept", cfg_if.cfg_ready, 1);
        tick();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_phase0 = 16'($urandom);
        cfg_if.cfg_fstart = 16'($urandom);
        cfg_if.cfg_fstep = 16'($urandom);
        cfg_if.cfg_count = 16'($urandom);
        i = 0;
        fired = 0;
        do begin
            abort = 1'b0;
            case (md)
                0: sample_en = 1'b1;
                1: sample_en = ($urandom % 10) < 7;
                default: sample_en = (i < 5) ? pat[i] : 1'b0;
            endcase
            if (glitch) begin
                cfg_if.cfg_valid = (i == 1 || i == 2);
                cfg_if.cfg_count = 16'd5;
            end
            if (!fired && ab_at > 0 && seen.size() == ab_at) begin
                abort = 1'b1;
                fired = 1;
            end
            if (!fired && rs_at > 0 && seen.size() == rs_at) begin
                reset = 1'b1;
                fired = 1;
            end
            tick();
            i++;
        end while (busy && i < 3000);
        abort = 1'b0;
        sample_en = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        if (i >= 3000) chk("burst_timeout", busy, 0);
    endtask

    initial begin
        logic [15:0] wrap_exp[3];
        logic [15:0] chirp_exp[4];
        wrap_exp = '{16'hF000, 16'h1000, 16'h3000};
        chirp_exp = '{16'h0000, 16'h0100, 16'h0210, 16'h0330};
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_phase0 = '0;
        cfg_if.cfg_fstart = '0;
        cfg_if.cfg_fstep = '0;
        cfg_if.cfg_count = '0;

        repeat (3) tick();
        chk("rst_x_start", x_start, 0);
        chk("rst_cfg_ready", cfg_if.cfg_ready, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", cfg_if.cfg_ready, 1);

        // fixed tone, 8 samples around the circle
        run_burst(16'h0000, 16'h2000, 16'h0000, 8, 0, 0, 0, 0);
        chk("t1_n_angles", seen.size(), 8);
        chk("t1_n_out", ov_cyc.size(), 8);
        if (seen.size() == 8 && ov_cyc.size() == 8) begin
            for (int j = 0; j < 8; j++) chk("t1_angle", seen[j], j * 32'h2000);
            chk("t1_av_span", av_cyc[7] - av_cyc[0], 7);
            chk("t1_latency", ov_cyc[0] - av_cyc[0], LAT);
            chk("t1_out_span", ov_cyc[7] - ov_cyc[0], 7);
            chk("t1_last_pos", last_cyc, ov_cyc[7]);
        end
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_pos", done_cyc, last_cyc + 1);
        chk("t1_ready", cfg_if.cfg_ready, 1);

        // phase wrap
        run_burst(16'hF000, 16'h2000, 16'h0000, 3, 0, 0, 0, 0);
        chk("t2_n_angles", seen.size(), 3);
        if (seen.size() == 3)
            for (int j = 0; j < 3; j++) chk("t2_angle", seen[j], wrap_exp[j]);
        chk("t2_x_start", x_start, 19898);
        chk("t2_y_start", y_start, 0);

        // chirp
        run_burst(16'h0000, 16'h0100, 16'h0010, 4, 0, 0, 0, 0);
        chk("t3_n_angles", seen.size(), 4);
        if (seen.size() == 4)
            for (int j = 0; j < 4; j++) chk("t3_angle", seen[j], chirp_exp[j]);

        // sample gaps 1,0,0,1,1
        run_burst(16'h0400, 16'h0800, 16'h0000, 3, 2, 0, 0, 0);
        chk("t4_n_angles", seen.size(), 3);
        chk("t4_n_out", ov_cyc.size(), 3);
        if (av_cyc.size() == 3 && ov_cyc.size() == 3) begin
            chk("t4_gap1", av_cyc[1] - av_cyc[0], 3);
            chk("t4_gap2", av_cyc[2] - av_cyc[0], 4);
            for (int j = 0; j < 3; j++) chk("t4_delay", ov_cyc[j] - av_cyc[j], LAT);
            chk("t4_last_pos", last_cyc, ov_cyc[2]);
        end
        chk("t4_done_cnt", done_cnt, 1);

        // abort after 3rd of 10 samples, with config offered during RUN
        run_burst(16'h0000, 16'h1000, 16'h0000, 10, 0, 3, 0, 1);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_ready", cfg_if.cfg_ready, 1);
        chk("t5_angle_held", angle, 16'h2000);
        repeat (25) tick();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_no_out", ov_cyc.size(), 0);
        chk("t5_n_angles", seen.size(), 3);

        // reset mid-burst
        run_burst(16'h1234, 16'h0777, 16'h0003, 20, 0, 0, 5, 0);
        chk("t6_angle", angle, 0);
        chk("t6_x_start", x_start, 0);
        chk("t6_angle_valid", angle_valid, 0);
        chk("t6_ready", cfg_if.cfg_ready, 0);
        chk("t6_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("t6_ready_back", cfg_if.cfg_ready, 1);

        // zero-length burst
        run_burst(16'h5555, 16'h0100, 16'h0000, 0, 0, 0, 0, 0);
        chk("t7_done_cnt", done_cnt, 1);
        chk("t7_no_angles", seen.size(), 0);
        chk("t7_no_out", ov_cyc.size(), 0);

        // random bursts against the model
        for (int b = 0; b < 30; b++) begin
            int cnt, ab;
            cnt = $urandom_range(1, 24);
            ab = ($urandom % 4 == 0) ? $urandom_range(1, cnt) : 0;
            run_burst(16'($urandom), 16'($urandom), 16'($urandom), cnt,
                      $urandom_range(0, 1), ab, 0, $urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
